// File: rtl/dc_fifo_hyper_pkg.sv
// -----------------------------------------------------------------------------
// dc_fifo_hyper_pkg
// Shared definitions for the HyperBus dual-clock token-ring FIFO halves.
//   TOKEN_RESET_DEFAULT : two-hot reset value of both token rings (bits 3:2).
//   token_to_pointer    : two-hot token -> one-hot pointer (rotl1(tok) & tok).
//   onehot_to_bin       : one-hot pointer -> binary index (fill-level option).
// Vectors are carried at MAX_DEPTH bits; callers zero-extend their ring and
// pass the real ring length so the rotation wraps at the correct bit.
// -----------------------------------------------------------------------------
package dc_fifo_hyper_pkg;

   localparam int unsigned MAX_DEPTH = 32;
   localparam int unsigned MAX_IDX_W = 5;

   localparam logic [MAX_DEPTH-1:0] TOKEN_RESET_DEFAULT = 32'h0000_000c;

   // Rotate left by one inside a ring of 'depth' bits, then AND with the
   // original: the single surviving bit is the upper bit of the two-hot pair.
   function automatic logic [MAX_DEPTH-1:0] token_to_pointer(
      input logic [MAX_DEPTH-1:0] token,
      input int unsigned          depth
   );
      logic [MAX_DEPTH-1:0] mask;
      logic [MAX_DEPTH-1:0] rot;
      mask = {MAX_DEPTH{1'b1}} >> (MAX_DEPTH - depth);
      rot  = ((token << 1) | (token >> (depth - 32'd1))) & mask;
      return rot & token;
   endfunction

   // Binary index of the set bit; zero when no bit is set.
   function automatic logic [MAX_IDX_W-1:0] onehot_to_bin(
      input logic [MAX_DEPTH-1:0] onehot
   );
      logic [MAX_IDX_W-1:0] bin;
      bin = '0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
         if (onehot[i]) begin
            bin = bin | MAX_IDX_W'(i);
         end else begin
            bin = bin;
         end
      end
      return bin;
   endfunction

endpackage

// File: rtl/dc_token_sync_hyper.sv
// -----------------------------------------------------------------------------
// dc_token_sync_hyper
// Two-flop synchronizer bank for a token vector crossing into the clk domain.
// Both stages reset synchronously to RESET_VALUE so that the synced token
// agrees with the (also reset) local ring right after reset.
// Ports:
//   clk     : destination clock
//   rst     : synchronous active-high reset
//   async_i : WIDTH-bit vector from the foreign clock domain
//   sync_o  : WIDTH-bit vector after two flops
// -----------------------------------------------------------------------------
module dc_token_sync_hyper #(
   parameter int unsigned       WIDTH       = 8,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o
);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;

   // Two-stage metastability filter.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= RESET_VALUE;
         sync2_q <= RESET_VALUE;
      end else begin
         sync1_q <= async_i;
         sync2_q <= sync1_q;
      end
   end

   assign sync_o = sync2_q;

endmodule

// File: rtl/dc_token_ring_fifo_dout_hyper.sv
// -----------------------------------------------------------------------------
// dc_token_ring_fifo_dout_hyper
// Read half of the HyperBus dual-clock token-ring FIFO. Synchronizes the
// write token, keeps the local read token ring, drives the one-hot read
// pointer to the buffer mux in the write half and registers the muxed word
// into a valid/ready output stage.
// Ports:
//   clk          : read-domain clock
//   rst          : synchronous active-high reset
//   data         : registered output word
//   valid        : output word valid
//   ready        : downstream accept
//   write_token  : two-hot write token (asynchronous, write domain)
//   read_pointer : one-hot read address to the write-half buffer mux
//   data_async   : buffer word selected by read_pointer (asynchronous)
//   level        : (only with DC_FIFO_HYPER_DOUT_LEVEL_EN) registered count
//                  of pending entries plus the word held in the output stage
// Optional feature macro: DC_FIFO_HYPER_DOUT_LEVEL_EN
// -----------------------------------------------------------------------------
module dc_token_ring_fifo_dout_hyper
   import dc_fifo_hyper_pkg::*;
#(
   parameter int unsigned              DATA_WIDTH   = 10,
   parameter int unsigned              BUFFER_DEPTH = 8,
   parameter logic [BUFFER_DEPTH-1:0]  TOKEN_RESET  = BUFFER_DEPTH'(TOKEN_RESET_DEFAULT)
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic [DATA_WIDTH-1:0]   data,
   output logic                    valid,
   input  logic                    ready,
   input  logic [BUFFER_DEPTH-1:0] write_token,
   output logic [BUFFER_DEPTH-1:0] read_pointer,
   input  logic [DATA_WIDTH-1:0]   data_async
`ifdef DC_FIFO_HYPER_DOUT_LEVEL_EN
   ,
   output logic [$clog2(BUFFER_DEPTH):0] level
`endif
);

   logic [BUFFER_DEPTH-1:0] sync_token_s;
   logic [BUFFER_DEPTH-1:0] sync_wptr_s;
   logic [BUFFER_DEPTH-1:0] read_pointer_s;
   logic [BUFFER_DEPTH-1:0] read_token_q;
   logic [BUFFER_DEPTH-1:0] read_token_d;
   logic [DATA_WIDTH-1:0]   data_q;
   logic [DATA_WIDTH-1:0]   data_d;
   logic                    valid_q;
   logic                    valid_d;
   logic                    empty_s;
   logic                    load_s;

   dc_token_sync_hyper #(
      .WIDTH       (BUFFER_DEPTH),
      .RESET_VALUE (TOKEN_RESET)
   ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (write_token),
      .sync_o  (sync_token_s)
   );

   // Pointer decode and empty/load decision.
   always_comb begin
      read_pointer_s = BUFFER_DEPTH'(token_to_pointer(MAX_DEPTH'(read_token_q), BUFFER_DEPTH));
      sync_wptr_s    = BUFFER_DEPTH'(token_to_pointer(MAX_DEPTH'(sync_token_s), BUFFER_DEPTH));
      // The write half stalls one entry early, so equality only ever means empty.
      empty_s        = (sync_wptr_s == read_pointer_s);
      // Load when data is pending and the output stage is free or being drained.
      load_s         = ~empty_s & (~valid_q | ready);
   end

   // Output stage and read ring next state.
   always_comb begin
      read_token_d = read_token_q;
      data_d       = data_q;
      valid_d      = valid_q;
      if (load_s) begin
         data_d       = data_async;
         valid_d      = 1'b1;
         read_token_d = {read_token_q[BUFFER_DEPTH-2:0], read_token_q[BUFFER_DEPTH-1]};
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Read ring and output stage registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         read_token_q <= TOKEN_RESET;
         data_q       <= '0;
         valid_q      <= 1'b0;
      end else begin
         read_token_q <= read_token_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
      end
   end

   assign data         = data_q;
   assign valid        = valid_q;
   assign read_pointer = read_pointer_s;

`ifdef DC_FIFO_HYPER_DOUT_LEVEL_EN
   localparam int unsigned LEVEL_W = $clog2(BUFFER_DEPTH) + 1;

   logic [LEVEL_W-1:0] level_q;
   logic [LEVEL_W-1:0] level_d;
   int unsigned        rbin_s;
   int unsigned        wbin_s;
   int unsigned        dist_s;

   // Ring distance from read to synced write pointer, plus the held word.
   always_comb begin
      rbin_s = 32'(onehot_to_bin(MAX_DEPTH'(read_pointer_s)));
      wbin_s = 32'(onehot_to_bin(MAX_DEPTH'(sync_wptr_s)));
      if (wbin_s >= rbin_s) begin
         dist_s = wbin_s - rbin_s;
      end else begin
         dist_s = wbin_s + BUFFER_DEPTH - rbin_s;
      end
      level_d = LEVEL_W'(dist_s + 32'(valid_q));
   end

   // Fill-level register.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= '0;
      end else begin
         level_q <= level_d;
      end
   end

   assign level = level_q;
`endif

endmodule

// File: tb/tb_dc_token_ring_fifo_dout_hyper.sv
// -----------------------------------------------------------------------------
// tb_dc_token_ring_fifo_dout_hyper
// Self-checking bench: a cycle table for reset and the first word, then
// scoreboard-driven sequences for backpressure, wrap-around, mid-stream
// reset and (with DC_FIFO_HYPER_DOUT_LEVEL_EN) the fill level. A small
// write-half model owns the buffer and the write token.
// -----------------------------------------------------------------------------
module tb_dc_token_ring_fifo_dout_hyper;

   localparam int DW = 10;
   localparam int D  = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          ready;
   logic [DW-1:0] data;
   logic [DW-1:0] data_async;
   logic          valid;
   logic [D-1:0]  write_token;
   logic [D-1:0]  read_pointer;
`ifdef DC_FIFO_HYPER_DOUT_LEVEL_EN
   logic [3:0]    level;
`endif

   logic [DW-1:0] mem [D];
   logic [D-1:0]  wtok;
   logic [DW-1:0] sb_q [$];
   int            errors = 0;
   int            checks = 0;

   typedef struct {
      logic          rst;
      logic          wr;
      logic [DW-1:0] wdata;
      logic          rdy;
      logic          exp_valid;
      logic [DW-1:0] exp_data;
      logic [D-1:0]  exp_rptr;
   } vec_t;

   vec_t tbl [18];

   dc_token_ring_fifo_dout_hyper #(
      .DATA_WIDTH   (DW),
      .BUFFER_DEPTH (D),
      .TOKEN_RESET  (8'hc)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .data         (data),
      .valid        (valid),
      .ready        (ready),
      .write_token  (write_token),
      .read_pointer (read_pointer),
      .data_async   (data_async)
`ifdef DC_FIFO_HYPER_DOUT_LEVEL_EN
      ,
      .level        (level)
`endif
   );

   always #5 clk = ~clk;

   assign write_token = wtok;

   // Write-half buffer mux.
   always_comb begin
      data_async = '0;
      for (int i = 0; i < D; i++) begin
         if (read_pointer[i]) data_async = mem[i];
      end
   end

   function automatic logic [D-1:0] rotl(input logic [D-1:0] v);
      return {v[D-2:0], v[D-1]};
   endfunction

   function automatic logic [D-1:0] ptr_of(input logic [D-1:0] tok);
      return rotl(tok) & tok;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model write: store at the write pointer, record expectation, advance token.
   task automatic write_word(input logic [DW-1:0] v);
      logic [D-1:0] wp;
      wp = ptr_of(wtok);
      for (int i = 0; i < D; i++) begin
         if (wp[i]) mem[i] = v;
      end
      sb_q.push_back(v);
      wtok = rotl(wtok);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Before an edge with ready=1: a valid word is accepted, compare it.
   task automatic sb_accept();
      if (valid && ready) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_word", 32'(data), 32'hffff_ffff);
         end else begin
            check("sb_data", 32'(data), 32'(sb_q.pop_front()));
         end
      end
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      wtok = 8'hc;
      sb_q.delete();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int            accepts;
      int            last_acc;
      int            written;
      int            received;
      int            changes;
      int            cyc;
      logic [D-1:0]  prev_rp;
      logic [DW-1:0] held;

      for (int i = 0; i < D; i++) mem[i] = '0;
      rst   = 1'b1;
      ready = 1'b0;
      wtok  = 8'hc;

      // ---------------- table: reset, idle, first word ----------------
      for (int i = 0; i < 18; i++) begin
         tbl[i] = '{rst: 1'b0, wr: 1'b0, wdata: 10'h0, rdy: 1'b1,
                    exp_valid: 1'b0, exp_data: 10'h0, exp_rptr: 8'h08};
      end
      for (int i = 0; i < 3; i++) tbl[i].rst = 1'b1;
      tbl[13].wr    = 1'b1;
      tbl[13].wdata = 10'h155;
      tbl[15].exp_valid = 1'b1;
      tbl[15].exp_data  = 10'h155;
      tbl[15].exp_rptr  = 8'h10;
      tbl[16].exp_data  = 10'h155;
      tbl[16].exp_rptr  = 8'h10;
      tbl[17].exp_data  = 10'h155;
      tbl[17].exp_rptr  = 8'h10;

      for (int i = 0; i < 18; i++) begin
         rst   = tbl[i].rst;
         ready = tbl[i].rdy;
         if (tbl[i].rst) wtok = 8'hc;
         if (tbl[i].wr) write_word(tbl[i].wdata);
         tick();
         check($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].exp_valid));
         check($sformatf("tbl%0d_data", i), 32'(data), 32'(tbl[i].exp_data));
         check($sformatf("tbl%0d_rptr", i), 32'(read_pointer), 32'(tbl[i].exp_rptr));
      end
      sb_q.delete();

      // ---------------- backpressure ----------------
      ready = 1'b0;
      write_word(10'h2a1); tick();
      write_word(10'h2a2); tick();
      write_word(10'h2a3); tick();
      tick(); tick();
      held = sb_q[0];
      for (int i = 0; i < 20; i++) begin
         check("bp_valid", 32'(valid), 32'd1);
         check("bp_data", 32'(data), 32'(held));
         check("bp_rptr", 32'(read_pointer), 32'h20);
         tick();
      end
      ready    = 1'b1;
      accepts  = 0;
      last_acc = -1;
      for (int i = 0; i < 8; i++) begin
         if (valid) begin
            accepts++;
            last_acc = i;
         end
         sb_accept();
         tick();
      end
      check("bp_accepts", 32'(accepts), 32'd3);
      check("bp_consecutive", 32'(last_acc), 32'd2);
      check("bp_sb_empty", 32'(sb_q.size()), 32'd0);

      // ---------------- wrap-around stream ----------------
      ready    = 1'b1;
      written  = 0;
      received = 0;
      changes  = 0;
      prev_rp  = read_pointer;
      cyc      = 0;
      while (received < 20 && cyc < 300) begin
         if (read_pointer !== prev_rp) begin
            check("wrap_rptr_step", 32'(read_pointer), 32'(rotl(prev_rp)));
            changes++;
            prev_rp = read_pointer;
         end
         if (valid) received++;
         sb_accept();
         if (written < 20 && ptr_of(rotl(wtok)) != read_pointer) begin
            write_word(10'(10'h300 + written));
            written++;
         end
         tick();
         cyc++;
      end
      check("wrap_received", 32'(received), 32'd20);
      check("wrap_rptr_changes", 32'(changes), 32'd20);
      check("wrap_sb_empty", 32'(sb_q.size()), 32'd0);

      // ---------------- mid-stream reset ----------------
      ready = 1'b0;
      write_word(10'h0a1); tick();
      write_word(10'h0a2); tick();
      write_word(10'h0a3); tick();
      cyc = 0;
      while (!valid && cyc < 10) begin
         tick();
         cyc++;
      end
      tick(); tick();
      check("mid_valid_before", 32'(valid), 32'd1);
      do_reset();
      check("mid_valid", 32'(valid), 32'd0);
      check("mid_data", 32'(data), 32'd0);
      check("mid_rptr", 32'(read_pointer), 32'h08);
      check("mid_sync1", 32'(dut.u_sync.sync1_q), 32'h0c);
      check("mid_sync2", 32'(dut.u_sync.sync2_q), 32'h0c);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("mid_idle_valid", 32'(valid), 32'd0);
      end

`ifdef DC_FIFO_HYPER_DOUT_LEVEL_EN
      // ---------------- fill level ----------------
      check("lvl_reset", 32'(level), 32'd0);
      ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         write_word(10'(10'h1c0 + i));
         tick();
      end
      for (int i = 0; i < 6; i++) tick();
      check("lvl_five", 32'(level), 32'd5);
      ready = 1'b1;
      sb_accept();
      tick();
      ready = 1'b0;
      tick(); tick();
      check("lvl_four", 32'(level), 32'd4);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
